// File: rtl/count_direction_decoder.sv
// Count direction decoder.
// Watches the value bus of a synchronous up/down counter and infers which way
// it is counting. It reports lock, stalls, direction reversals, wrap-arounds
// and illegal jumps, and keeps a saturating tally of the illegal jumps.
// Every output is registered, so each one describes the step prev -> count_in
// one cycle after count_in was sampled.
module count_direction_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir,
    output logic             locked,
    output logic             hold,
    output logic             dir_change,
    output logic             wrap,
    output logic             err,
    output logic [ERRW-1:0]  err_cnt
);

    // The streak counter only has to reach LOCK_CNT.
    localparam int SW = $clog2(LOCK_CNT + 1);
    localparam logic [SW-1:0]    LOCK_N  = SW'(LOCK_CNT);
    localparam logic [WIDTH-1:0] MAXV    = '1;
    localparam logic [ERRW-1:0]  ERR_MAX = '1;

    // ACQ0: first sample after reset, nothing to compare against yet.
    // ACQ1: building a streak of consistent +/-1 steps.
    // LOCKED: direction established, steps are checked against it.
    typedef enum logic [1:0] {
        ACQ0   = 2'd0,
        ACQ1   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [SW-1:0]    streak, streak_nxt;
    logic             cand_dir, cand_dir_nxt;
    logic             dir_nxt, locked_nxt, hold_nxt;
    logic             dir_change_nxt, wrap_nxt, err_nxt;
    logic [ERRW-1:0]  err_cnt_nxt;

    logic [WIDTH-1:0] delta;
    logic             is_up, is_dn, is_zero, is_bad, step_dir;

    // Classify the step from the previous sample; subtraction wraps mod 2^WIDTH.
    always_comb begin
        delta    = count_in - prev;
        is_up    = (delta == WIDTH'(1));
        is_dn    = (delta == MAXV);
        is_zero  = (delta == '0);
        is_bad   = !(is_up || is_dn || is_zero);
        step_dir = is_dn;
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_nxt      = state;
        prev_nxt       = count_in;
        streak_nxt     = streak;
        cand_dir_nxt   = cand_dir;
        dir_nxt        = dir;
        locked_nxt     = locked;
        hold_nxt       = hold;
        dir_change_nxt = 1'b0;
        wrap_nxt       = 1'b0;
        err_nxt        = 1'b0;
        err_cnt_nxt    = err_cnt;

        case (state)
            ACQ0: begin
                state_nxt = ACQ1;
            end
            ACQ1: begin
                hold_nxt = is_zero;
                if (is_up || is_dn) begin
                    if ((step_dir == cand_dir) && (streak != '0)) begin
                        streak_nxt = streak + 1'b1;
                    end else begin
                        cand_dir_nxt = step_dir;
                        streak_nxt   = SW'(1);
                    end
                end else if (is_bad) begin
                    streak_nxt = '0;
                end
                if (streak_nxt == LOCK_N) begin
                    state_nxt  = LOCKED;
                    locked_nxt = 1'b1;
                    dir_nxt    = cand_dir_nxt;
                end
            end
            LOCKED: begin
                hold_nxt = is_zero;
                if (is_up || is_dn) begin
                    if (step_dir != dir) begin
                        dir_nxt        = step_dir;
                        dir_change_nxt = 1'b1;
                    end
                    // A +1 step landing on 0 came from max; a -1 step landing on max came from 0.
                    wrap_nxt = (is_up && (count_in == '0)) || (is_dn && (count_in == MAXV));
                end else if (is_bad) begin
                    err_nxt    = 1'b1;
                    locked_nxt = 1'b0;
                    streak_nxt = '0;
                    state_nxt  = ACQ1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt_nxt = err_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ACQ0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ACQ0;
            prev       <= '0;
            streak     <= '0;
            cand_dir   <= 1'b0;
            dir        <= 1'b0;
            locked     <= 1'b0;
            hold       <= 1'b0;
            dir_change <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            streak     <= streak_nxt;
            cand_dir   <= cand_dir_nxt;
            dir        <= dir_nxt;
            locked     <= locked_nxt;
            hold       <= hold_nxt;
            dir_change <= dir_change_nxt;
            wrap       <= wrap_nxt;
            err        <= err_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_count_direction_decoder.sv
// Bench for count_direction_decoder: directed scenarios followed by random
// counter traffic, all checked against a behavioural model of the decoder.
module tb_count_direction_decoder;

    localparam int W    = 4;
    localparam int L    = 3;
    localparam int E    = 8;
    localparam int MODV = 1 << W;
    localparam int MAXV = MODV - 1;
    localparam int EMAX = (1 << E) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] count_in = '0;
    logic         dir, locked, hold, dir_change, wrap, err;
    logic [E-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit m_seen, m_locked, m_dir;
    bit e_hold, e_dc, e_wrap, e_err;
    int m_prev, m_cnt;
    bit m_hist[$];   // directions of +/-1 steps seen while acquiring

    count_direction_decoder #(.WIDTH(W), .LOCK_CNT(L), .ERRW(E)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .dir        (dir),
        .locked     (locked),
        .hold       (hold),
        .dir_change (dir_change),
        .wrap       (wrap),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    // Clock.
    always #5 clk = ~clk;

    // One comparison: immediate assertion that counts and reports a failure.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model one clock edge. Lock means: the last L nonzero steps since
    // acquisition began (or since the last illegal jump) all go the same way.
    task automatic model_edge(input bit r, input int cur);
        int d;
        bit sd;
        bit all_same;
        e_dc   = 1'b0;
        e_wrap = 1'b0;
        e_err  = 1'b0;
        if (!r) begin
            m_seen   = 1'b0;
            m_locked = 1'b0;
            m_dir    = 1'b0;
            e_hold   = 1'b0;
            m_cnt    = 0;
            m_prev   = 0;
            m_hist.delete();
            return;
        end
        if (!m_seen) begin
            m_seen = 1'b1;
            m_prev = cur;
            return;
        end
        d = (cur - m_prev + MODV) % MODV;
        e_hold = (d == 0);
        if (d == 1 || d == MAXV) begin
            sd = (d == MAXV);
            if (!m_locked) begin
                m_hist.push_back(sd);
                if (m_hist.size() >= L) begin
                    all_same = 1'b1;
                    for (int i = 0; i < L; i++)
                        if (m_hist[m_hist.size() - 1 - i] != sd) all_same = 1'b0;
                    if (all_same) begin
                        m_locked = 1'b1;
                        m_dir    = sd;
                    end
                end
            end else begin
                if (sd != m_dir) begin
                    e_dc  = 1'b1;
                    m_dir = sd;
                end
                e_wrap = (!sd && m_prev == MAXV && cur == 0) || (sd && m_prev == 0 && cur == MAXV);
            end
        end else if (d != 0) begin
            m_hist.delete();
            if (m_locked) begin
                e_err    = 1'b1;
                m_locked = 1'b0;
                if (m_cnt < EMAX) m_cnt++;
            end
        end
        m_prev = cur;
    endtask

    // Drive one sample, clock it, then compare every output with the model.
    task automatic step(input bit r, input int cur);
        rst      = r;
        count_in = W'(cur);
        @(posedge clk);
        model_edge(r, cur);
        #1;
        check("dir",        32'(dir),        32'(m_dir));
        check("locked",     32'(locked),     32'(m_locked));
        check("hold",       32'(hold),       32'(e_hold));
        check("dir_change", 32'(dir_change), 32'(e_dc));
        check("wrap",       32'(wrap),       32'(e_wrap));
        check("err",        32'(err),        32'(e_err));
        check("err_cnt",    32'(err_cnt),    32'(m_cnt));
    endtask

    initial begin
        int c;
        int r;
        int mode;

        // Reset state.
        step(1'b0, 0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_errcnt", 32'(err_cnt), 32'd0);

        // T1 up lock.
        step(1'b1, 0);
        step(1'b1, 1);
        step(1'b1, 2);
        check("t1_not_yet", 32'(locked), 32'd0);
        step(1'b1, 3);
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_dir", 32'(dir), 32'd0);

        // T2 wrap max -> 0.
        for (int v = 4; v <= 15; v++) step(1'b1, v);
        step(1'b1, 0);
        check("t2_wrap", 32'(wrap), 32'd1);
        step(1'b1, 1);
        check("t2_wrap_end", 32'(wrap), 32'd0);
        check("t2_locked", 32'(locked), 32'd1);

        // T3 reversal.
        for (int v = 2; v <= 6; v++) step(1'b1, v);
        step(1'b1, 5);
        check("t3_dc", 32'(dir_change), 32'd1);
        check("t3_dir", 32'(dir), 32'd1);
        step(1'b1, 4);
        check("t3_dc_end", 32'(dir_change), 32'd0);

        // T4 illegal jump and relock.
        step(1'b0, 0);
        for (int v = 0; v <= 3; v++) step(1'b1, v);
        step(1'b1, 9);
        check("t4_err", 32'(err), 32'd1);
        check("t4_errcnt", 32'(err_cnt), 32'd1);
        check("t4_unlocked", 32'(locked), 32'd0);
        step(1'b1, 10);
        step(1'b1, 11);
        step(1'b1, 12);
        check("t4_relock", 32'(locked), 32'd1);

        // T5 stall while counting down.
        for (int v = 11; v >= 7; v--) step(1'b1, v);
        step(1'b1, 7);
        check("t5_hold1", 32'(hold), 32'd1);
        step(1'b1, 7);
        check("t5_hold2", 32'(hold), 32'd1);
        step(1'b1, 6);
        check("t5_hold_end", 32'(hold), 32'd0);
        check("t5_dir", 32'(dir), 32'd1);

        // T6 reset mid-run with err_cnt=2.
        step(1'b1, 0);
        check("t6_errcnt2", 32'(err_cnt), 32'd2);
        step(1'b1, 1);
        step(1'b1, 2);
        step(1'b1, 3);
        step(1'b0, 4);
        check("t6_rst_errcnt", 32'(err_cnt), 32'd0);
        check("t6_rst_locked", 32'(locked), 32'd0);
        step(1'b1, 5);
        step(1'b1, 6);
        step(1'b1, 7);
        check("t6_not_yet", 32'(locked), 32'd0);
        step(1'b1, 8);
        check("t6_relock", 32'(locked), 32'd1);

        // Error counter saturation.
        c = 8;
        for (int k = 0; k < EMAX + 5; k++) begin
            c = (c + 7) % MODV;
            step(1'b1, c);
            for (int j = 0; j < L; j++) begin
                c = (c + 1) % MODV;
                step(1'b1, c);
            end
        end
        check("sat_errcnt", 32'(err_cnt), 32'(EMAX));

        // Random counter traffic with stalls, reversals, jumps and resets.
        mode = 0;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 8) mode = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1'b0, $urandom_range(0, MAXV));
            end else begin
                if (r < 12)      c = c;
                else if (r < 18) c = $urandom_range(0, MAXV);
                else if (mode == 0) c = (c + 1) % MODV;
                else                c = (c + MAXV) % MODV;
                step(1'b1, c);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
